score_display_driver: RTL and testbench

Parametrised binary-to-seven-segment display driver for the game's score and status readouts. It accepts a binary value through a valid/ready handshake and converts it to BCD with a sequential shift-and-add-3 (double-dabble) engine, one bit per cycle. It holds the result in a display register and drives DIGITS active-low seven-segment outputs, with leading-zero suppression, per-digit masking, overflow saturation and an optional blink mode. It sits between game-state logic and the board HEX pins.

---
 rtl/score_display_driver.sv | 203 ++++++++++++++++++++
 tb/tb_score_display_driver.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_display_driver.sv
// rtl/score_display_driver.sv - binary to active-low seven-segment display driver, double-dabble conversion
// Optional blink feature: define DISPLAY_BLINK_EN to build the blink counter.
module score_display_driver #(
  parameter int DIGITS       = 8,
  parameter int BIN_W        = 16,
  parameter int BLINK_CYCLES = 25_000_000
) (
  input  logic                clock,
  input  logic                reset_L,
  input  logic                value_valid,
  input  logic [BIN_W-1:0]    value,
  output logic                value_ready,
  input  logic                lz_blank,
  input  logic [DIGITS-1:0]   blank_mask,
  input  logic                blink,
  output logic                busy,
  output logic                overflow,
  output logic [7*DIGITS-1:0] HEX
);

  localparam int          BCD_W   = 4 * DIGITS;
  localparam int          CNT_W   = $clog2(BIN_W);
  localparam logic [31:0] MAX_VAL = 32'(10 ** DIGITS - 1);

  // Reject configurations the datapath is not sized for.
  if (DIGITS < 1 || DIGITS > 8 || BIN_W < 4 || BIN_W > 27 || BLINK_CYCLES < 1) begin : g_param_check
    $error("score_display_driver: parameter out of range");
  end

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    LOAD
  } state_t;

  state_t             state;
  state_t             state_next;
  logic               accept;
  logic               last_bit;

  logic [BIN_W-1:0]   shift_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [BCD_W-1:0]   bcd_adj;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_q;

  logic [BCD_W-1:0]   disp_q;
  logic               disp_blank_q;

  logic               blink_phase;
  logic [3:0]         nib;
  logic               seen_nonzero;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the left shift.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] r;
    r = bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd[4*d +: 4] >= 4'd5) begin
        r[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  // Active-high segment pattern, bit 0 = a ... bit 6 = g.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h67;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  assign last_bit = (cnt_q == CNT_W'(BIN_W - 1));
  assign bcd_adj  = add3(bcd_q);

  // State register.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake/status outputs.
  always_comb begin
    state_next  = state;
    value_ready = 1'b0;
    busy        = 1'b0;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        value_ready = 1'b1;
        if (value_valid) begin
          accept     = 1'b1;
          state_next = CONVERT;
        end
      end
      CONVERT: begin
        busy = 1'b1;
        if (last_bit) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        busy       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Conversion engine: capture on accept, then one shift-and-add-3 step per cycle.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      shift_q <= value;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= (32'(value) > MAX_VAL);
    end else if (state == CONVERT) begin
      {bcd_q, shift_q} <= {bcd_adj, shift_q} << 1;
      cnt_q            <= cnt_q + 1'b1;
    end
  end

  // Display register: only updated in LOAD so partial results never reach the pins.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      disp_q       <= '0;
      disp_blank_q <= 1'b1;
      overflow     <= 1'b0;
    end else if (state == LOAD) begin
      disp_q       <= ovf_q ? {DIGITS{4'h9}} : bcd_q;
      disp_blank_q <= 1'b0;
      overflow     <= ovf_q;
    end
  end

`ifdef DISPLAY_BLINK_EN
  localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  logic [BLINK_W-1:0] blink_cnt_q;
  logic               blink_phase_q;

  // Blink timebase; held at zero while blink is low so blinking starts visible.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (!blink) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (blink_cnt_q == BLINK_W'(BLINK_CYCLES - 1)) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= ~blink_phase_q;
    end else begin
      blink_cnt_q   <= blink_cnt_q + 1'b1;
    end
  end

  assign blink_phase = blink_phase_q;
`else
  assign blink_phase = 1'b0;
`endif

  // Segment decode with blanking; scans from the top digit to find leading zeros.
  always_comb begin
    HEX          = '1;
    seen_nonzero = 1'b0;
    nib          = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib = disp_q[4*i +: 4];
      if (nib != 4'd0) begin
        seen_nonzero = 1'b1;
      end
      if (disp_blank_q || blank_mask[i] ||
          (lz_blank && !seen_nonzero && (i != 0)) ||
          (blink && blink_phase)) begin
        HEX[7*i +: 7] = 7'h7F;
      end else begin
        HEX[7*i +: 7] = ~seg7(nib);
      end
    end
  end

endmodule

// File: tb/tb_score_display_driver.sv
// tb/tb_score_display_driver.sv - randomized self-checking bench for score_display_driver
module tb_score_display_driver;

  localparam int DIGITS       = 4;
  localparam int BIN_W        = 16;
  localparam int BLINK_CYCLES = 4;
  localparam int MAXV         = 9999;

  localparam logic [6:0] SEG [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                       7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h67};
  localparam logic [7*DIGITS-1:0] ALL_BLANK = {DIGITS{7'h7F}};
  localparam logic [7*DIGITS-1:0] HEX_1234  = {7'h79, 7'h24, 7'h30, 7'h19};
  localparam logic [7*DIGITS-1:0] HEX_4321  = {7'h19, 7'h30, 7'h24, 7'h79};
  localparam logic [7*DIGITS-1:0] HEX_0_LZ  = {7'h7F, 7'h7F, 7'h7F, 7'h40};
  localparam logic [7*DIGITS-1:0] HEX_905_LZ = {7'h7F, 7'h18, 7'h40, 7'h12};
  localparam logic [7*DIGITS-1:0] HEX_9999  = {7'h18, 7'h18, 7'h18, 7'h18};

  logic                clock = 1'b0;
  logic                reset_L = 1'b0;
  logic                value_valid = 1'b0;
  logic [BIN_W-1:0]    value = '0;
  logic                value_ready;
  logic                lz_blank = 1'b0;
  logic [DIGITS-1:0]   blank_mask = '0;
  logic                blink = 1'b0;
  logic                busy;
  logic                overflow;
  logic [7*DIGITS-1:0] HEX;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  // Reference model state: cycles left until load, pending value, shown value.
  int m_cnt   = 0;
  int m_pend  = 0;
  int m_disp  = 0;
  bit m_shown = 1'b0;
  bit m_ovf   = 1'b0;
  int m_k     = 0;

  score_display_driver #(
    .DIGITS(DIGITS),
    .BIN_W(BIN_W),
    .BLINK_CYCLES(BLINK_CYCLES)
  ) dut (
    .clock(clock),
    .reset_L(reset_L),
    .value_valid(value_valid),
    .value(value),
    .value_ready(value_ready),
    .lz_blank(lz_blank),
    .blank_mask(blank_mask),
    .blink(blink),
    .busy(busy),
    .overflow(overflow),
    .HEX(HEX)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a value accepted at edge T is shown after edge T+BIN_W+1.
  always @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      m_cnt   <= 0;
      m_shown <= 1'b0;
      m_ovf   <= 1'b0;
      m_disp  <= 0;
      m_k     <= 0;
    end else begin
      m_k <= blink ? m_k + 1 : 0;
      if (m_cnt == 0) begin
        if (value_valid) begin
          m_pend <= int'(value);
          m_cnt  <= BIN_W + 1;
        end
      end else begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_shown <= 1'b1;
          m_ovf   <= (m_pend > MAXV);
          m_disp  <= (m_pend > MAXV) ? MAXV : m_pend;
        end
      end
    end
  end

  function automatic logic [7*DIGITS-1:0] model_hex();
    logic [7*DIGITS-1:0] h;
    int p;
    int d;
    bit phase;
`ifdef DISPLAY_BLINK_EN
    phase = ((m_k / BLINK_CYCLES) % 2) == 1;
`else
    phase = 1'b0;
`endif
    p = 1;
    h = '1;
    for (int i = 0; i < DIGITS; i++) begin
      d = (m_disp / p) % 10;
      if (!m_shown || blank_mask[i] || (lz_blank && i > 0 && m_disp < p) || (blink && phase))
        h[7*i +: 7] = 7'h7F;
      else
        h[7*i +: 7] = ~SEG[d];
      p = p * 10;
    end
    return h;
  endfunction

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    if (cmp_en) begin
      chk("value_ready", value_ready, (m_cnt == 0));
      chk("busy", busy, (m_cnt != 0));
      chk("overflow", overflow, m_ovf);
      chk("HEX", HEX, model_hex());
    end
  end

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!value_ready && n < 60) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk(name, value_ready, 1'b1);
  endtask

  task automatic load(input int v);
    wait_ready("ready_before_load");
    value       = BIN_W'(v);
    value_valid = 1'b1;
    @(posedge clock);
    #1;
    value_valid = 1'b0;
    wait_ready("ready_after_load");
    @(negedge clock);
  endtask

  initial begin
    // Reset state.
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_HEX", HEX, ALL_BLANK);
    chk("reset_ready", value_ready, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_overflow", overflow, 1'b0);
    cmp_en = 1'b1;
    @(posedge clock);
    #1;
    reset_L = 1'b1;
    repeat (3) @(negedge clock);
    chk("post_reset_HEX", HEX, ALL_BLANK);

    // Directed values.
    load(1234);
    chk("hex_1234", HEX, HEX_1234);
    chk("ovf_1234", overflow, 1'b0);
    lz_blank = 1'b1;
    load(0);
    chk("hex_0_lz", HEX, HEX_0_LZ);
    load(905);
    chk("hex_905_lz", HEX, HEX_905_LZ);
    load(10000);
    chk("hex_10000_sat", HEX, HEX_9999);
    chk("ovf_10000", overflow, 1'b1);
    load(9999);
    chk("hex_9999", HEX, HEX_9999);
    chk("ovf_9999", overflow, 1'b0);

    // A new value presented during conversion is ignored.
    lz_blank = 1'b0;
    wait_ready("ready_before_ignore");
    value       = 16'd4321;
    value_valid = 1'b1;
    @(posedge clock);
    #1;
    value = 16'd777;
    repeat (5) @(posedge clock);
    #1;
    chk("ready_low_in_convert", value_ready, 1'b0);
    value_valid = 1'b0;
    wait_ready("ready_after_ignore");
    @(negedge clock);
    chk("hex_4321_intact", HEX, HEX_4321);

    // Reset in the middle of a conversion.
    wait_ready("ready_before_abort");
    value       = 16'd55;
    value_valid = 1'b1;
    @(posedge clock);
    #1;
    value_valid = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    reset_L = 1'b0;
    @(negedge clock);
    chk("abort_HEX", HEX, ALL_BLANK);
    chk("abort_busy", busy, 1'b0);
    @(posedge clock);
    #1;
    reset_L = 1'b1;
    repeat (4) @(negedge clock);
    chk("abort_idle_ready", value_ready, 1'b1);
    chk("abort_still_blank", HEX, ALL_BLANK);

    // Blink: visible for BLINK_CYCLES, then blank, starting visible.
    load(1234);
    @(posedge clock);
    #1;
    blink = 1'b1;
    for (int n = 0; n < 16; n++) begin
      @(negedge clock);
`ifdef DISPLAY_BLINK_EN
      chk("blink_phase", HEX, (((n / 4) % 2) == 1) ? ALL_BLANK : HEX_1234);
`else
      chk("blink_ignored", HEX, HEX_1234);
`endif
    end
    @(posedge clock);
    #1;
    blink = 1'b0;
    repeat (3) @(negedge clock);
    chk("blink_off_steady", HEX, HEX_1234);

    // Back-to-back acceptance with value_valid held high.
    @(posedge clock);
    #1;
    value_valid = 1'b1;
    for (int n = 0; n < 80; n++) begin
      value = BIN_W'($urandom_range(0, 12000));
      @(posedge clock);
      #1;
    end
    value_valid = 1'b0;

    // Randomized traffic with masks, suppression, blink and occasional resets.
    for (int n = 0; n < 1500; n++) begin
      if (!reset_L) reset_L = 1'b1;
      else if ($urandom_range(0, 199) == 0) reset_L = 1'b0;
      value_valid = ($urandom_range(0, 2) == 0);
      value       = ($urandom_range(0, 3) == 0) ? BIN_W'($urandom_range(0, 65535))
                                                : BIN_W'($urandom_range(0, 12000));
      if ($urandom_range(0, 7) == 0) lz_blank = ~lz_blank;
      if ($urandom_range(0, 7) == 0) blank_mask = DIGITS'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) blink = ~blink;
      @(posedge clock);
      #1;
    end
    reset_L     = 1'b1;
    value_valid = 1'b0;
    repeat (BIN_W + 4) @(posedge clock);
    @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
